// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multi-cycle MIPS core. Sequences the shared ALU, the unified
//   instruction/data memory port, PC, IR and register file over several cycles per
//   instruction. Adds a memory ready handshake with a timeout, a sticky fault trap and
//   a retired-instruction counter.
//
// State table:
//   FETCH  | read instruction at PC; on mem_ready load IR and PC <= PC+4
//   DECODE | branch target into ALUOut, dispatch on op/funct
//   MEMADR | ALUOut <= rs + imm for lw/sw
//   MEMRD  | data read at ALUOut, waits for mem_ready
//   MEMWB  | rt <= mem data register, retire
//   MEMWR  | data write at ALUOut, retire on mem_ready
//   EXEC_R | R-type ALU op on rs, rt
//   RWB    | rd <= ALUOut, retire
//   EXEC_I | addi/andi ALU op on rs, imm
//   IWB    | rt <= ALUOut, retire
//   BRANCH | compare rs, rt; conditional PC <= ALUOut, retire
//   JUMP   | PC <= jump target, retire
//   JR     | PC <= rs, retire
//   JAL    | PC <= jump target, $31 <= PC, retire
//   FAULT  | all enables off, fault asserted, held until reset
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_op, i_funct         IR[31:26], IR[5:0]
//   i_zero                ALU zero flag
//   i_mem_ready           memory completes the current access this cycle
//   o_mem_req/o_mem_write/o_iord          memory port control
//   o_ir_write/o_pc_write/o_pc_src        IR and PC load control
//   o_reg_write/o_reg_dst/o_mem_to_reg    register file write control
//   o_alu_src_a/o_alu_src_b/o_ext_zero/o_alu_control  ALU operand and op select
//   o_instr_done          one-cycle retire pulse
//   o_retire_count        retired instruction count (wraps)
//   o_fault               sticky illegal-instruction / memory-timeout flag
//
// Outputs are decoded from the current state; only the FETCH writes (gated by
// mem_ready), the MEMWR retire (mem_ready) and the BRANCH pc_write (zero) look at inputs.

module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [5:0]          i_op,
  input  logic [5:0]          i_funct,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_mem_req,
  output logic                o_mem_write,
  output logic                o_iord,
  output logic                o_ir_write,
  output logic                o_pc_write,
  output logic [1:0]          o_pc_src,
  output logic                o_reg_write,
  output logic [1:0]          o_reg_dst,
  output logic [1:0]          o_mem_to_reg,
  output logic                o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic                o_ext_zero,
  output logic [2:0]          o_alu_control,
  output logic                o_instr_done,
  output logic [RETIRE_W-1:0] o_retire_count,
  output logic                o_fault
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // A fault is raised on the MEM_TIMEOUT-th consecutive cycle without mem_ready,
  // i.e. while the counter still holds MEM_TIMEOUT-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R, S_RWB,
    S_EXEC_I, S_IWB, S_BRANCH, S_JUMP, S_JR, S_JAL, S_FAULT
  } state_t;

  state_t                r_state;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic                  r_fault;
  logic [RETIRE_W-1:0]   r_retire_count;

  logic                  w_wait_hit;
  logic [WAIT_W-1:0]     w_wait_inc;
  logic                  w_funct_alu;

  assign w_wait_hit  = (MEM_TIMEOUT != 0) && !i_mem_ready && (r_wait_cnt == WAIT_LAST);
  // Saturate so a disabled timeout never wraps the counter.
  assign w_wait_inc  = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
  assign w_funct_alu = (i_funct == FN_ADD) || (i_funct == FN_SUB) || (i_funct == FN_AND) ||
                       (i_funct == FN_OR)  || (i_funct == FN_SLT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_FETCH;
      r_wait_cnt     <= '0;
      r_fault        <= 1'b0;
      r_retire_count <= '0;
    end else begin
      if (o_instr_done) r_retire_count <= r_retire_count + RETIRE_W'(1);
      case (r_state)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          // The counter is only nonzero inside a memory state and is cleared on
          // every exit, so each memory state is entered with a fresh count.
          if (i_mem_ready) begin
            r_wait_cnt <= '0;
            case (r_state)
              S_FETCH: r_state <= S_DECODE;
              S_MEMRD: r_state <= S_MEMWB;
              default: r_state <= S_FETCH;
            endcase
          end else if (w_wait_hit) begin
            r_wait_cnt <= '0;
            r_state    <= S_FAULT;
            r_fault    <= 1'b1;
          end else begin
            r_wait_cnt <= w_wait_inc;
          end
        end
        S_DECODE: begin
          case (i_op)
            OP_LW, OP_SW:     r_state <= S_MEMADR;
            OP_BEQ, OP_BNE:   r_state <= S_BRANCH;
            OP_ADDI, OP_ANDI: r_state <= S_EXEC_I;
            OP_J:             r_state <= S_JUMP;
            OP_JAL:           r_state <= S_JAL;
            OP_RTYPE: begin
              if (i_funct == FN_JR) begin
                r_state <= S_JR;
              end else if (w_funct_alu) begin
                r_state <= S_EXEC_R;
              end else begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
              end
            end
            default: begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end
          endcase
        end
        S_MEMADR: r_state <= (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_EXEC_R: r_state <= S_RWB;
        S_EXEC_I: r_state <= S_IWB;
        S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JR, S_JAL: r_state <= S_FETCH;
        S_FAULT:  r_fault <= 1'b1;
        default: begin
          r_state <= S_FAULT;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    o_mem_req     = 1'b0;
    o_mem_write   = 1'b0;
    o_iord        = 1'b0;
    o_ir_write    = 1'b0;
    o_pc_write    = 1'b0;
    o_pc_src      = 2'b00;
    o_reg_write   = 1'b0;
    o_reg_dst     = 2'b00;
    o_mem_to_reg  = 2'b00;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = 2'b00;
    o_ext_zero    = 1'b0;
    o_alu_control = ALU_ADD;
    o_instr_done  = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_write  = 1'b1;
          o_pc_write  = 1'b1;
          o_alu_src_b = 2'b01;
        end
      end
      S_DECODE: o_alu_src_b = 2'b11;
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'b01;
        o_instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_mem_req    = 1'b1;
        o_mem_write  = 1'b1;
        o_iord       = 1'b1;
        o_instr_done = i_mem_ready;
      end
      S_EXEC_R: begin
        o_alu_src_a = 1'b1;
        case (i_funct)
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_AND:  o_alu_control = ALU_AND;
          FN_OR:   o_alu_control = ALU_OR;
          FN_SLT:  o_alu_control = ALU_SLT;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      S_RWB: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = 2'b01;
        o_instr_done = 1'b1;
      end
      S_EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        if (i_op == OP_ANDI) begin
          o_alu_control = ALU_AND;
          o_ext_zero    = 1'b1;
        end
      end
      S_IWB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a   = 1'b1;
        o_alu_control = ALU_SUB;
        o_pc_src      = 2'b01;
        o_pc_write    = (i_op == OP_BNE) ? ~i_zero : i_zero;
        o_instr_done  = 1'b1;
      end
      S_JUMP: begin
        o_pc_write   = 1'b1;
        o_pc_src     = 2'b10;
        o_instr_done = 1'b1;
      end
      S_JR: begin
        o_pc_write   = 1'b1;
        o_pc_src     = 2'b11;
        o_instr_done = 1'b1;
      end
      S_JAL: begin
        o_pc_write   = 1'b1;
        o_pc_src     = 2'b10;
        o_reg_write  = 1'b1;
        o_reg_dst    = 2'b10;
        o_mem_to_reg = 2'b10;
        o_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_fault        = r_fault;
  assign o_retire_count = r_retire_count;

endmodule
